// File: rtl/hazard_ctrl_unit.sv
// Hazard detection and pipeline control for the MIPS-subset pipeline: decodes the ID
// instruction, tracks in-flight destinations EX..WB and drives stall, bubble and forwarding.
module hazard_ctrl_unit #(
    parameter int DEPTH       = 3,
    parameter int FWD_EN      = 0,
    parameter int RF_WR_FIRST = 1,
    parameter int CNT_W       = 16,
    parameter int SEL_W       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             flush,
    output logic             stall,
    output logic             wpcir,
    output logic             idex_bubble,
    output logic [SEL_W-1:0] fwd_a,
    output logic [SEL_W-1:0] fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WIN = DEPTH - RF_WR_FIRST;

    logic [5:0] op;
    logic [5:0] func;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;

    assign op   = id_instr[31:26];
    assign rs   = id_instr[25:21];
    assign rt   = id_instr[20:16];
    assign rd   = id_instr[15:11];
    assign func = id_instr[5:0];

    logic unused_instr_bits;
    assign unused_instr_bits = ^{id_instr[10:6], func[1:0]};

    logic       dec_has_dst;
    logic [4:0] dec_dst;
    logic       dec_use_rs;
    logic       dec_use_rt;
    logic       dec_is_load;
    logic       dec_vld;

    always_comb begin
        dec_has_dst = 1'b0;
        dec_dst     = 5'd0;
        dec_use_rs  = 1'b0;
        dec_use_rt  = 1'b0;
        dec_is_load = 1'b0;
        if (id_valid) begin
            case (op)
                6'b000000: begin
                    dec_has_dst = 1'b1;
                    dec_dst     = rd;
                    dec_use_rt  = 1'b1;
                    // shifts take their operand from rt only
                    dec_use_rs  = (func[5:2] != 4'b0000);
                end
                6'b100011: begin
                    dec_has_dst = 1'b1;
                    dec_dst     = rt;
                    dec_use_rs  = 1'b1;
                    dec_is_load = 1'b1;
                end
                6'b101011, 6'b000100: begin
                    dec_use_rs = 1'b1;
                    dec_use_rt = 1'b1;
                end
                6'b001000, 6'b001100, 6'b001101: begin
                    dec_has_dst = 1'b1;
                    dec_dst     = rt;
                    dec_use_rs  = 1'b1;
                end
                default: ;
            endcase
        end
        dec_vld = dec_has_dst && (dec_dst != 5'd0);
    end

    // Scoreboard index 0 is stage 1 (EX).
    logic [DEPTH-1:0] sb_vld_q;
    logic [DEPTH-1:0] sb_vld_d;
    logic [DEPTH-1:0] sb_ld_q;
    logic [DEPTH-1:0] sb_ld_d;
    logic [4:0]       sb_dst_q [DEPTH];
    logic [4:0]       sb_dst_d [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [DEPTH-1:0] match_a;
    logic [DEPTH-1:0] match_b;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             stall_raw;

    always_comb begin
        match_a = '0;
        match_b = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < WIN) begin
                match_a[k] = dec_use_rs && (rs != 5'd0) && sb_vld_q[k] && (sb_dst_q[k] == rs);
                match_b[k] = dec_use_rt && (rt != 5'd0) && sb_vld_q[k] && (sb_dst_q[k] == rt);
            end
        end
        // scan oldest to youngest so the youngest matching stage overwrites
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match_a[k]) sel_a = SEL_W'(k + 1);
            if (match_b[k]) sel_b = SEL_W'(k + 1);
        end
        if (FWD_EN != 0) stall_raw = (match_a[0] | match_b[0]) & sb_ld_q[0];
        else             stall_raw = |(match_a | match_b);
    end

    always_comb begin
        stall       = stall_raw & ~flush & ~rst;
        wpcir       = ~stall;
        idex_bubble = (stall | flush) & ~rst;
        fwd_a       = '0;
        fwd_b       = '0;
        if ((FWD_EN != 0) && !stall && !rst) begin
            fwd_a = sel_a;
            fwd_b = sel_b;
        end
    end

    always_comb begin
        sb_vld_d[0] = dec_vld && !(stall || flush);
        sb_ld_d[0]  = dec_is_load && !(stall || flush);
        sb_dst_d[0] = dec_dst;
        for (int k = 1; k < DEPTH; k++) begin
            sb_vld_d[k] = sb_vld_q[k-1];
            sb_ld_d[k]  = sb_ld_q[k-1];
            sb_dst_d[k] = sb_dst_q[k-1];
        end
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_vld_q <= '0;
            sb_ld_q  <= '0;
            for (int k = 0; k < DEPTH; k++) sb_dst_q[k] <= 5'd0;
            cnt_q    <= '0;
        end else begin
            sb_vld_q <= sb_vld_d;
            sb_ld_q  <= sb_ld_d;
            for (int k = 0; k < DEPTH; k++) sb_dst_q[k] <= sb_dst_d[k];
            cnt_q    <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised hazard detection and pipeline-control block for the pipelined MIPS-subset CPU. It decodes the instruction in ID and keeps a registered scoreboard of destination registers for the in-flight stages EX..WB. From these it drives the stall/PC-write controls, ID/EX bubble insertion, operand-forwarding selects and a stall performance counter. It supports a stall-only mode and a forwarding mode, with configurable pipeline depth and register-file write-through.

Parameters:
DEPTH, 3, number of tracked stages after ID (stage 1 = EX, 2 = MEM, 3 = WB).
FWD_EN, 0, 0 = resolve every RAW hazard by stalling; 1 = forward, stall only on load-use.
RF_WR_FIRST, 1, 1 = register file writes before it reads in the same cycle, so stage DEPTH is excluded from the hazard window.
CNT_W, 16, width of the stall counter.
SEL_W, 2, width of the forwarding selects; must be at least clog2(DEPTH+1).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
id_instr  in  32  instruction currently in ID
id_valid  in  1  id_instr is a real instruction (0 = bubble)
flush  in  1  taken branch; squash the ID instruction this cycle
stall  out  1  hazard detected; hold PC and IF/ID
wpcir  out  1  PC / IF/ID write enable, equal to ~stall
idex_bubble  out  1  load a bubble into ID/EX (stall | flush)
fwd_a  out  SEL_W  rs operand source: 0 = register file, k = stage k result
fwd_b  out  SEL_W  rt operand source, same encoding
stall_cnt  out  CNT_W  count of stalled cycles, saturating

Behaviour:
- Decode of id_instr:
  - R-type (op 000000): destination rd; uses rs and rt. If func[5:2]==0 (shift), it uses rt only.
  - LW (100011): destination rt; uses rs; flagged as load.
  - SW (101011) and BEQ (000100): no destination; use rs and rt.
  - ADDI/ANDI/ORI (001000/001100/001101): destination rt; uses rs.
  - Any other opcode, or id_valid=0: no destination, no sources.
  - A destination of $0 is treated as no destination.
- Scoreboard: DEPTH entries, each {valid, dst[4:0], is_load}. Every cycle it shifts stage k to stage k+1 and drops stage DEPTH.
- Stage 1 loads the decoded ID entry. If stall or flush is asserted, stage 1 loads an invalid entry (bubble) instead.
- Hazard window: stages 1..DEPTH-RF_WR_FIRST.
- A source matches stage k when the source is used, nonzero, and equal to a valid stage-k dst.
- FWD_EN=0:
  - stall = any source matches any stage in the window.
  - fwd_a = fwd_b = 0.
- FWD_EN=1:
  - stall = a source matches stage 1 and stage 1 is_load.
  - fwd_x = the lowest k in the window with a match (youngest wins), else 0.
  - fwd_x is forced to 0 while stall is asserted.
- Priority: flush overrides stall. When flush=1, stall=0, wpcir=1 and idex_bubble=1.
- Timing: stall, fwd_a, fwd_b, wpcir and idex_bubble are combinational from id_instr, id_valid, flush and the registered scoreboard. Scoreboard and counter are registered.
- A held instruction re-evaluates each cycle. Bubbles advance, so a load-use hazard costs exactly 1 stall cycle in FWD_EN=1. With DEPTH=3, RF_WR_FIRST=1, FWD_EN=0, a back-to-back dependency costs 2 stall cycles.
- stall_cnt increments on each clock edge where stall=1 and rst=0. It saturates at all-ones and does not wrap.
- Reset (rst=1 at an edge, including mid-operation):
  - All scoreboard entries become invalid and stall_cnt becomes 0.
  - While rst=1, the outputs are forced to stall=0, wpcir=1, idex_bubble=0, fwd_a=fwd_b=0.
- First cycle after reset: no hazard possible, since the scoreboard is empty.

Test Plan:
1. FWD_EN=0: ID 0x8C410000 (lw $1), then 0x00221820 (add $3,$1,$2) -> add stalls 2 cycles (stall=1, wpcir=0, idex_bubble=1), then issues; stall_cnt=2.
2. FWD_EN=1, same pair -> stall for exactly 1 cycle; the next cycle has stall=0 and fwd_a=2 (MEM); stall_cnt=1.
3. FWD_EN=1: 0x00221820 then 0x00632020 (add $4,$3,$3) -> no stall, fwd_a=fwd_b=1. Insert one unrelated instruction between them -> fwd_a=fwd_b=2.
4. 0x00210020 (add $0,$1,$1) then 0x00002820 (add $5,$0,$0) -> never stalls, fwd=0 in both modes.
5. Flush=1 in a cycle where case 1 would stall -> stall=0, idex_bubble=1; the next instruction sees no hazard from the squashed entry.
6. Assert rst mid-stall in case 1 -> after the edge, stall_cnt=0, stall=0, and the dependent add proceeds without stall. With CNT_W=2 and 5 stall cycles, stall_cnt holds at 3.
